// File: rtl/mem_access_pkg.sv
// Shared definitions for the MEM-stage load/store unit: FSM states, funct3
// encodings, the load/store opcodes (also used by the decoder) and an
// access-size decode helper.
package mem_access_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2
    } size_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

    // Any funct3 that is not a legal byte/half encoding for the op is a word access.
    function automatic size_t access_size(input logic is_store, input logic [2:0] f3);
        if (f3 == F3_B || (!is_store && f3 == F3_BU))
            return SZ_B;
        else if (f3 == F3_H || (!is_store && f3 == F3_HU))
            return SZ_H;
        else
            return SZ_W;
    endfunction

endpackage

// File: rtl/mem_access_load_extend.sv
// Load data lane selection and sign/zero extension. Purely combinational;
// the halfword lane is picked by offset[1] so odd offsets fold down.
module load_extend
    import mem_access_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  offset,
    input  logic [2:0]  funct3,
    output logic [31:0] data
);

    logic [7:0]         lane_byte;
    logic [15:0]        lane_half;
    logic signed [7:0]  byte_s;
    logic signed [15:0] half_s;

    // Pick the addressed lane, then extend according to funct3
    always_comb begin
        lane_byte = rdata[{offset, 3'b000} +: 8];
        lane_half = offset[1] ? rdata[31:16] : rdata[15:0];
        byte_s    = lane_byte;
        half_s    = lane_half;
        case (funct3)
            F3_B:    data = 32'(byte_s);
            F3_BU:   data = {24'd0, lane_byte};
            F3_H:    data = 32'(half_s);
            F3_HU:   data = {16'd0, lane_half};
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store responder: single-outstanding req/ack bus transaction,
// byte-enable / store-lane generation, load extension and pipeline stall.
// Optional feature macro: MEM_ACCESS_MISALIGN_TRAP_EN (misaligned halfword/word
// accesses complete without a bus cycle and raise `misaligned`).
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  memRead,
    input  logic                  memWrite,
    input  logic [2:0]            funct3,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [31:0]           writeData,
    output logic [31:0]           readData,
    output logic                  done,
    output logic                  stall,
    output logic                  busReq,
    output logic                  busWe,
    output logic [ADDR_WIDTH-1:0] busAddr,
    output logic [31:0]           busWdata,
    output logic [3:0]            busBe,
    input  logic                  busAck,
    input  logic [31:0]           busRdata
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
    ,
    output logic                  misaligned
`endif
);

    state_t      state, next_state;
    logic [2:0]  f3_q;
    logic [1:0]  off_q;
    logic        req;
    logic        trap;
    size_t       size_in;
    logic [3:0]  be_in;
    logic [31:0] wdata_in;
    logic [31:0] load_data;

    assign req     = memRead | memWrite;
    assign stall   = req & (state != DONE);
    // A simultaneous load+store is treated as a store.
    assign size_in = access_size(memWrite, funct3);

`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
    logic mis_q;
    assign trap       = (size_in == SZ_H && addr[0]) ||
                        (size_in == SZ_W && addr[1:0] != 2'b00);
    assign misaligned = (state == DONE) & mis_q;
`else
    assign trap = 1'b0;
`endif

    // Byte enables and lane-replicated store data for the incoming request
    always_comb begin
        be_in    = 4'b1111;
        wdata_in = writeData;
        if (memWrite) begin
            case (size_in)
                SZ_B: begin
                    be_in    = 4'b0001 << addr[1:0];
                    wdata_in = {4{writeData[7:0]}};
                end
                SZ_H: begin
                    be_in    = 4'b0011 << {addr[1], 1'b0};
                    wdata_in = {2{writeData[15:0]}};
                end
                default: ;
            endcase
        end
    end

    // FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= next_state;
    end

    // FSM next-state and control outputs
    always_comb begin
        next_state = state;
        busReq     = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (req)
                    next_state = trap ? DONE : BUS;
            end
            BUS: begin
                busReq = 1'b1;
                if (busAck)
                    next_state = DONE;
            end
            DONE: begin
                done       = 1'b1;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Capture the request; bus outputs stay stable until the next accept
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busAddr  <= '0;
            busWe    <= 1'b0;
            busBe    <= 4'b0000;
            busWdata <= 32'd0;
            f3_q     <= 3'd0;
            off_q    <= 2'd0;
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
            mis_q    <= 1'b0;
`endif
        end else if (state == IDLE && req) begin
            busAddr  <= {addr[ADDR_WIDTH-1:2], 2'b00};
            busWe    <= memWrite;
            busBe    <= be_in;
            busWdata <= wdata_in;
            f3_q     <= funct3;
            off_q    <= addr[1:0];
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
            mis_q    <= trap;
`endif
        end
    end

    load_extend u_load_extend (
        .rdata  (busRdata),
        .offset (off_q),
        .funct3 (f3_q),
        .data   (load_data)
    );

    // Load result register; only a completing load updates it
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            readData <= 32'd0;
        else if (state == BUS && busAck && !busWe)
            readData <= load_data;
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed vector table, reset
// corner cases and randomized accesses against a behavioural model.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        memRead, memWrite;
    logic [2:0]  funct3;
    logic [31:0] addr, writeData;
    logic [31:0] readData;
    logic        done, stall, busReq, busWe;
    logic [31:0] busAddr, busWdata;
    logic [3:0]  busBe;
    logic        busAck;
    logic [31:0] busRdata;
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
    logic        misaligned;
`endif

    int total_cnt = 0;
    int pass_cnt  = 0;
    logic [31:0] last_rd = 32'd0;

    always #5 clk = ~clk;

    mem_access_unit #(.ADDR_WIDTH(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .memRead   (memRead),
        .memWrite  (memWrite),
        .funct3    (funct3),
        .addr      (addr),
        .writeData (writeData),
        .readData  (readData),
        .done      (done),
        .stall     (stall),
        .busReq    (busReq),
        .busWe     (busWe),
        .busAddr   (busAddr),
        .busWdata  (busWdata),
        .busBe     (busBe),
        .busAck    (busAck),
        .busRdata  (busRdata)
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
        ,
        .misaligned(misaligned)
`endif
    );

    typedef struct {
        logic        rd;
        logic        wr;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] wd;
        logic [31:0] rdat;
        int          dly;
        logic [3:0]  be;
        logic [31:0] wdat;
        logic [31:0] baddr;
        logic [31:0] rdv;
    } vec_t;

    vec_t tbl[11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp)
            pass_cnt++;
        else
            $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ---------------- behavioural reference model ----------------
    function automatic int m_size(input logic wr, input logic [2:0] f3);
        int f = int'(f3);
        if (wr) return (f == 0) ? 1 : (f == 1) ? 2 : 4;
        return (f == 0 || f == 4) ? 1 : (f == 1 || f == 5) ? 2 : 4;
    endfunction

    function automatic logic [3:0] m_be(input logic wr, input logic [2:0] f3, input logic [31:0] a);
        int sz  = m_size(wr, f3);
        int off = int'(a % 4);
        if (!wr || sz == 4) return 4'd15;
        if (sz == 1) return 4'(1 << off);
        return 4'(3 << ((off / 2) * 2));
    endfunction

    function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] wd);
        int sz = m_size(1'b1, f3);
        if (sz == 1) return (wd % 256) * 32'h01010101;
        if (sz == 2) return (wd % 65536) * 32'h00010001;
        return wd;
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] rdat);
        int sz  = m_size(1'b0, f3);
        int off = int'(a % 4);
        longint v;
        if (sz == 1) begin
            v = (rdat >> (8 * off)) % 256;
            if (f3 == 3'd0 && v >= 128) v = v - 256;
            return 32'(v);
        end
        if (sz == 2) begin
            v = (rdat >> (8 * ((off / 2) * 2))) % 65536;
            if (f3 == 3'd1 && v >= 32768) v = v - 65536;
            return 32'(v);
        end
        return rdat;
    endfunction

    function automatic logic m_trap(input logic wr, input logic [2:0] f3, input logic [31:0] a);
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
        int sz = m_size(wr, f3);
        return (sz == 2 && a % 2 != 0) || (sz == 4 && a % 4 != 0);
`else
        return 1'b0;
`endif
    endfunction

    // One complete access: request, optional wait states, ack, DONE, back to IDLE
    task automatic do_access(input logic rd, input logic wr, input logic [2:0] f3,
                             input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rdat,
                             input int dly, input logic [3:0] ebe, input logic [31:0] ewd,
                             input logic [31:0] eaddr, input logic [31:0] erd, input logic trap);
        int stall_cnt = 0;
        memRead = rd; memWrite = wr; funct3 = f3; addr = a; writeData = wd;
        #1;
        check("stall_on_request", stall, 1'b1);
        check("no_busreq_idle", busReq, 1'b0);
        if (stall) stall_cnt++;
        step();
        if (trap) begin
            check("trap_done", done, 1'b1);
            check("trap_no_busreq", busReq, 1'b0);
            check("trap_stall_low", stall, 1'b0);
            check("trap_readdata", readData, erd);
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
            check("trap_misaligned", misaligned, 1'b1);
`endif
        end else begin
            check("busreq", busReq, 1'b1);
            check("busaddr", busAddr, eaddr);
            check("busbe", busBe, ebe);
            check("buswe", busWe, wr);
            if (wr) check("buswdata", busWdata, ewd);
            if (stall) stall_cnt++;
            for (int i = 0; i < dly; i++) begin
                step();
                check("busreq_wait", busReq, 1'b1);
                check("busaddr_wait", busAddr, eaddr);
                check("no_done_wait", done, 1'b0);
                if (stall) stall_cnt++;
            end
            busAck = 1'b1; busRdata = rdat;
            step();
            busAck = 1'b0; busRdata = $urandom;
            check("done_pulse", done, 1'b1);
            check("stall_low_done", stall, 1'b0);
            check("busreq_dropped", busReq, 1'b0);
            check("readdata", readData, erd);
            check("stall_cycles", stall_cnt, dly + 2);
        end
        memRead = 1'b0; memWrite = 1'b0;
        step();
        check("done_one_cycle", done, 1'b0);
        check("readdata_hold", readData, erd);
        last_rd = erd;
    endtask

    initial begin
        logic tr;
        logic [31:0] erd;

        reset = 1'b1; memRead = 1'b0; memWrite = 1'b0; funct3 = 3'd0;
        addr = 32'd0; writeData = 32'd0; busAck = 1'b0; busRdata = 32'd0;

        //               rd    wr    f3      addr          wdata         busRdata    dly be     busWdata      busAddr       readData
        tbl[0]  = '{1'b1, 1'b0, 3'b010, 32'h0000_0100, 32'h0,        32'hDEADBEEF, 0, 4'hF, 32'h0,        32'h0000_0100, 32'hDEADBEEF};
        tbl[1]  = '{1'b0, 1'b1, 3'b000, 32'h0000_0103, 32'h0000_00A5, 32'h0,       0, 4'h8, 32'hA5A5A5A5, 32'h0000_0100, 32'hDEADBEEF};
        tbl[2]  = '{1'b1, 1'b0, 3'b000, 32'h0000_0102, 32'h0,        32'h0080FF00, 0, 4'hF, 32'h0,        32'h0000_0100, 32'hFFFFFF80};
        tbl[3]  = '{1'b1, 1'b0, 3'b100, 32'h0000_0102, 32'h0,        32'h0080FF00, 1, 4'hF, 32'h0,        32'h0000_0100, 32'h00000080};
        tbl[4]  = '{1'b1, 1'b0, 3'b010, 32'h0000_0200, 32'h0,        32'h12345678, 3, 4'hF, 32'h0,        32'h0000_0200, 32'h12345678};
        tbl[5]  = '{1'b0, 1'b1, 3'b001, 32'h0000_0002, 32'hBEEF1234, 32'h0,       0, 4'hC, 32'h12341234, 32'h0000_0000, 32'h12345678};
        tbl[6]  = '{1'b1, 1'b0, 3'b001, 32'h0000_0003, 32'h0,        32'h80010000, 0, 4'hF, 32'h0,        32'h0000_0000, 32'hFFFF8001};
        tbl[7]  = '{1'b1, 1'b0, 3'b101, 32'h0000_0003, 32'h0,        32'h80010000, 0, 4'hF, 32'h0,        32'h0000_0000, 32'h00008001};
        tbl[8]  = '{1'b1, 1'b0, 3'b010, 32'h0000_0101, 32'h0,        32'hCAFEF00D, 2, 4'hF, 32'h0,        32'h0000_0100, 32'hCAFEF00D};
        tbl[9]  = '{1'b1, 1'b1, 3'b010, 32'h0000_0010, 32'h11223344, 32'h55555555, 0, 4'hF, 32'h11223344, 32'h0000_0010, 32'hCAFEF00D};
        tbl[10] = '{1'b1, 1'b0, 3'b011, 32'h0000_0000, 32'h0,        32'h87654321, 0, 4'hF, 32'h0,        32'h0000_0000, 32'h87654321};

        // Reset state
        #2;
        check("rst_busreq", busReq, 1'b0);
        check("rst_buswe", busWe, 1'b0);
        check("rst_busbe", busBe, 4'h0);
        check("rst_busaddr", busAddr, 32'h0);
        check("rst_buswdata", busWdata, 32'h0);
        check("rst_readdata", readData, 32'h0);
        check("rst_done", done, 1'b0);
        check("rst_stall", stall, 1'b0);
        step();
        reset = 1'b0;
        step();

        // Directed vectors
        for (int i = 0; i < 11; i++) begin
            tr  = m_trap(tbl[i].wr, tbl[i].f3, tbl[i].a);
            erd = tbl[i].rdv;
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
            if (tr || tbl[i].wr) erd = last_rd;
`endif
            do_access(tbl[i].rd, tbl[i].wr, tbl[i].f3, tbl[i].a, tbl[i].wd, tbl[i].rdat,
                      tbl[i].dly, tbl[i].be, tbl[i].wdat, tbl[i].baddr, erd, tr);
        end

        // Reset in the middle of a bus cycle, followed by a stray ack
        memRead = 1'b1; funct3 = 3'b010; addr = 32'h0000_0300;
        #1;
        step();
        check("mid_busreq_before", busReq, 1'b1);
        #2 reset = 1'b1;
        #1;
        check("mid_busreq_async_drop", busReq, 1'b0);
        check("mid_readdata_cleared", readData, 32'h0);
        check("mid_no_done", done, 1'b0);
        memRead = 1'b0;
        step();
        reset = 1'b0;
        busAck = 1'b1; busRdata = 32'hFFFF_FFFF;
        step();
        busAck = 1'b0;
        check("stray_ack_no_done", done, 1'b0);
        check("stray_ack_no_busreq", busReq, 1'b0);
        check("stray_ack_readdata", readData, 32'h0);
        step();
        check("stray_ack_still_idle", done, 1'b0);
        last_rd = 32'h0;

        // Recovery access after the abandoned transaction
        do_access(1'b1, 1'b0, 3'b010, 32'h0000_0400, 32'h0, 32'h0BADF00D, 0,
                  4'hF, 32'h0, 32'h0000_0400, 32'h0BADF00D, 1'b0);

        // Randomized accesses against the model
        for (int n = 0; n < 60; n++) begin
            int          k;
            logic        rd, wr;
            logic [2:0]  f3;
            logic [31:0] a, wd, rdat;
            int          dly;
            k    = $urandom_range(0, 2);
            rd   = (k != 1);
            wr   = (k != 0);
            f3   = 3'($urandom_range(0, 7));
            a    = $urandom;
            wd   = $urandom;
            rdat = $urandom;
            dly  = $urandom_range(0, 3);
            tr   = m_trap(wr, f3, a);
            erd  = (!wr && !tr) ? m_load(f3, a, rdat) : last_rd;
            do_access(rd, wr, f3, a, wd, rdat, dly, m_be(wr, f3, a), m_wdata(f3, wd),
                      (a / 4) * 4, erd, tr);
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
